// File: rtl/mem_wb_skid_reg.sv
// MEM->WB boundary register with valid/ready handshake and two-entry skid.
// in_ready is decoded from state only; wb_value_out selects load data or ALU result.
module mem_wb_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     data_memory_result_in,
    input  logic [REG_ADDR_W-1:0] wb_reg_dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     data_memory_result_out,
    output logic [REG_ADDR_W-1:0] wb_reg_dest_out,
    output logic [DATA_W-1:0]     wb_value_out
);

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     dmem;
        logic [REG_ADDR_W-1:0] dest;
    } ent_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    ent_t   r_main;
    ent_t   r_skid;
    ent_t   w_in;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_ld_main_in;
    logic   w_ld_main_skid;
    logic   w_ld_skid;

    assign in_ready   = (r_state != S_FULL);
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign w_in = '{
        wb_en:    wb_en_in,
        mem_r_en: mem_r_en_in,
        alu:      alu_result_in,
        dmem:     data_memory_result_in,
        dest:     wb_reg_dest_in
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) w_next = S_ONE;
                S_ONE: begin
                    if (w_in_fire && !w_out_fire) w_next = S_FULL;
                    else if (!w_in_fire && w_out_fire) w_next = S_EMPTY;
                end
                S_FULL:  if (w_out_fire) w_next = S_ONE;
                default: w_next = S_EMPTY;
            endcase
        end
    end

    // Flush squashes every load so nothing from the flush cycle is kept.
    always_comb begin
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_ld_main_in = w_in_fire;
                S_ONE: begin
                    w_ld_main_in = w_in_fire & w_out_fire;
                    w_ld_skid    = w_in_fire & ~w_out_fire;
                end
                S_FULL:  w_ld_main_skid = w_out_fire;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) r_main <= w_in;
            else if (w_ld_main_skid) r_main <= r_skid;
            if (w_ld_skid) r_skid <= w_in;
        end
    end

    assign wb_en_out              = r_main.wb_en & out_valid;
    assign mem_r_en_out           = r_main.mem_r_en;
    assign alu_result_out         = r_main.alu;
    assign data_memory_result_out = r_main.dmem;
    assign wb_reg_dest_out        = r_main.dest;
    assign wb_value_out           = r_main.mem_r_en ? r_main.dmem : r_main.alu;

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM→WB pipeline boundary register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a built-in write-back value select. Sits between the data-memory stage and the register-file write port. Replaces the plain always-load stage register wherever the write-back side can stall, for example on a multi-cycle register-file port or a shared write-back bus. Sustains one transfer per cycle with no combinational path from out_ready to in_ready.

## Interface
- DATA_W, 32, width of the ALU result and memory data fields
- REG_ADDR_W, 4, width of the destination register index
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  block can accept an entry this cycle
- wb_en_in  in  1  entry writes the register file
- mem_r_en_in  in  1  entry is a load
- alu_result_in  in  DATA_W  ALU result
- data_memory_result_in  in  DATA_W  memory read data
- wb_reg_dest_in  in  REG_ADDR_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes the head entry
- wb_en_out  out  1  head wb_en, gated by out_valid
- mem_r_en_out  out  1  head mem_r_en
- alu_result_out  out  DATA_W  head ALU result
- data_memory_result_out  out  DATA_W  head memory data
- wb_reg_dest_out  out  REG_ADDR_W  head destination
- wb_value_out  out  DATA_W  if mem_r_en_out is 1, data_memory_result_out; otherwise alu_result_out

## Operation
**Storage**
- Main register: the head entry, which drives all *_out ports.
- Skid register: a second entry of the same fields.

**State machine** (EMPTY, ONE, FULL)
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready = (state != FULL). It is decoded from state only.
- out_valid = (state != EMPTY).

**Transitions**
- EMPTY: in_fire → main ← input, go to ONE.
- ONE:
  - in_fire & out_fire → main ← input, stay in ONE.
  - in_fire only → skid ← input, go to FULL.
  - out_fire only → go to EMPTY.
- FULL:
  - in_fire is impossible.
  - out_fire → main ← skid, go to ONE.

**Flush**
- flush has priority over all transitions.
- Next state is EMPTY.
- An input presented in the same cycle is discarded, even if in_fire is high.
- A same-cycle out_fire still counts as consumed.

**Output gating**
- wb_en_out = main.wb_en & out_valid. This prevents spurious register writes when the block is empty.
- Other payload outputs hold their last value when not valid; consumers must ignore them.
- wb_value_out is purely combinational from the main register.

**Ordering**
- Entries leave in strict arrival order.
- No entry is duplicated or dropped, except by flush.

## Timing
**Reset**
- rst_n low immediately forces state EMPTY, out_valid 0, wb_en_out 0 and in_ready 1.
- All payload registers (main and skid) reset to 0, so mem_r_en_out, alu_result_out, data_memory_result_out, wb_reg_dest_out and wb_value_out all read 0.
- Inputs are ignored while rst_n is low.
- Reset mid-operation loses all held entries; there is no partial state.

**Latency and throughput**
- Latency: input accepted at edge N is visible on *_out after edge N when the block was empty or draining; out_valid is 1 in the cycle after acceptance.
- Throughput: 1 entry per cycle while out_ready stays high.

**Backpressure**
- out_ready low for one cycle: entries in flight land in skid, and in_ready drops the following cycle.
- in_ready reasserts the cycle after the first out_fire in FULL.

**Combinational paths**
- None from out_ready or out_valid to in_ready.
- None from any input to out_valid.

**Handshake rule**
- Upstream may change in_valid or payload only when in_valid is 0 or in_fire occurred.

## Test plan
1. **Reset values:** with rst_n low while in_valid=1 and alu_result_in=0xDEAD → out_valid=0, wb_en_out=0, in_ready=1, all payload outputs 0. After release, in_valid=1 with wb_en_in=1, alu_result_in=5, wb_reg_dest_in=3 → next cycle out_valid=1, wb_en_out=1, wb_value_out=5, wb_reg_dest_out=3.
2. **Streaming:** out_ready=1 with 8 back-to-back entries, alu_result 1..8 → outputs 1..8 on consecutive cycles, in_ready constantly 1.
3. **Skid:** hold out_ready=0 while presenting A=0x10, then B=0x20 → in_ready=0 after B. Raise out_ready → 0x10 then 0x20, in_ready=1 one cycle after the first pop.
4. **Write-back select:** an entry with mem_r_en_in=1, data_memory_result_in=0xAA, alu_result_in=0x40 → wb_value_out=0xAA. The same entry with mem_r_en_in=0 → wb_value_out=0x40.
5. **Flush in FULL:** assert flush together with in_valid → next cycle out_valid=0, wb_en_out=0, in_ready=1. Neither held entry nor the flush-cycle input ever appears on the output.
6. **Async reset mid-stream:** assert rst_n low between clock edges while FULL → outputs go to reset values immediately. After release, the first new entry emerges alone with no stale data.
